uart_tx_buffer: RTL and testbench

//   Host-side transmit stage directly upstream of the UART top. Buffers bytes written in the system
//   clk domain and presents them one at a time on the UART Tx_valid/Tx_err/input_tx inputs.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_buffer_fifo.sv | 59 +++++
 rtl/uart_tx_buffer.sv | 124 ++++++++++++
 tb/tb_uart_tx_buffer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the host-side UART transmit buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DRAIN   = 2'd2
    } tx_buf_state_t;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous show-ahead FIFO: rd_data always reflects the head entry; rd_en advances it.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == CNT_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule

// File: rtl/uart_tx_buffer.sv
// Host-side transmit buffer: queues bytes and hands them to the UART one at a time,
// paced by the resynchronised UART ready signal.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int WIDTH_SIZE  = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH_SIZE-1:0]    wr_data,
    input  logic                     wr_err,
    input  logic                     clr_ovf,
    input  logic                     uart_ready,
    output logic                     Tx_valid,
    output logic                     Tx_err,
    output logic [WIDTH_SIZE-1:0]    input_tx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ready_s;
    tx_buf_state_t          r_state;
    tx_buf_state_t          w_next_state;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_drop;
    logic [WIDTH_SIZE:0]    w_rd_data;
    logic [WIDTH_SIZE-1:0]  r_data;
    logic                   r_err;
    logic                   r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_ready};
        end
    end

    assign w_ready_s = r_sync[SYNC_STAGES-1];

    // A pop frees a slot in the same cycle, so a write to a full FIFO is still accepted then.
    assign w_wr   = wr_en && (!full || w_pop);
    assign w_drop = wr_en && full && !w_pop;

    sync_fifo #(
        .WIDTH (WIDTH_SIZE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_data ({wr_err, wr_data}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!empty && w_ready_s) begin
                    w_pop        = 1'b1;
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (!w_ready_s) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_ready_s) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_pop) begin
            r_data <= w_rd_data[WIDTH_SIZE-1:0];
            r_err  <= w_rd_data[WIDTH_SIZE];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign Tx_valid = (r_state == PRESENT);
    assign Tx_err   = r_err;
    assign input_tx = r_data;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: cycle-exact vector table plus handshake sequences.
module tb_uart_tx_buffer;

    localparam int W = 8;
    localparam int D = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         wr_err;
    logic         clr_ovf;
    logic         uart_ready;
    logic         Tx_valid;
    logic         Tx_err;
    logic [W-1:0] input_tx;
    logic         full;
    logic         empty;
    logic [$clog2(D):0] count;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    uart_tx_buffer #(
        .WIDTH_SIZE  (W),
        .DEPTH       (D),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .clr_ovf    (clr_ovf),
        .uart_ready (uart_ready),
        .Tx_valid   (Tx_valid),
        .Tx_err     (Tx_err),
        .input_tx   (input_tx),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [W-1:0] wd;
        logic         werr;
        logic         rdy;
        logic         ev;
        logic [W-1:0] ed;
        logic         ee;
        int           ec;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(logic we, logic [W-1:0] wd, logic werr, logic rdy,
                                logic ev, logic [W-1:0] ed, logic ee, int ec);
        vec_t v;
        v.we = we; v.wd = wd; v.werr = werr; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ec = ec;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic write1(input logic [W-1:0] d, input logic e);
        wr_en = 1'b1; wr_data = d; wr_err = e;
        tick();
        wr_en = 1'b0; wr_err = 1'b0;
    endtask

    // UART model: wait for a presented byte, accept it by dropping ready,
    // keep ready low for 'hold' cycles, then signal frame done.
    task automatic uart_take(input int hold, output logic [W-1:0] d, output logic e, output bit ok);
        int n;
        ok = 1'b0; d = '0; e = 1'b0;
        n = 0;
        while (Tx_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (Tx_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL uart_take_valid_timeout actual=0 expected=1");
            return;
        end
        d = input_tx; e = Tx_err;
        uart_ready = 1'b0;
        n = 0;
        while (Tx_valid !== 1'b0 && n < 20) begin
            tick();
            if (Tx_valid === 1'b1) chk("held_data_stable", int'(input_tx), int'(d));
            n++;
        end
        if (Tx_valid !== 1'b0) begin
            checks++; failures++;
            $display("FAIL uart_take_release_timeout actual=1 expected=0");
            return;
        end
        repeat (hold) tick();
        uart_ready = 1'b1;
        ok = 1'b1;
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_d;
    logic         got_e;
    bit           got_ok;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_err = 1'b0;
        clr_ovf = 1'b0; uart_ready = 1'b1;

        // Reset values
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", int'(Tx_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_input_tx", int'(input_tx), 0);

        // Reset mid-PRESENT with 3 queued
        repeat (3) tick();
        write1(8'h11, 1'b0);
        write1(8'h22, 1'b0);
        write1(8'h33, 1'b0);
        write1(8'h44, 1'b0);
        chk("pre_rst_valid", int'(Tx_valid), 1);
        chk("pre_rst_count", int'(count), 3);
        chk("pre_rst_data", int'(input_tx), 'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_valid", int'(Tx_valid), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_ovf", int'(overflow), 0);
        repeat (3) tick();
        chk("midrst_idle_no_emit", int'(Tx_valid), 0);

        // Cycle-exact table: single byte handshake, then an error-flagged byte
        vt[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1);
        vt[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 0);
        vt[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 0);
        vt[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 0);
        vt[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        vt[5]  = mk(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1);
        vt[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1);
        vt[7]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1);
        vt[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 0);
        vt[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 0);
        vt[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 0);
        vt[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        vt[12] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0);
        vt[13] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0);
        vt[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            wr_en = vt[i].we; wr_data = vt[i].wd; wr_err = vt[i].werr; uart_ready = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), int'(Tx_valid), int'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].ec);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_data", i), int'(input_tx), int'(vt[i].ed));
                chk($sformatf("vec%0d_err", i), int'(Tx_err), int'(vt[i].ee));
            end
        end
        wr_en = 1'b0; wr_err = 1'b0;

        // Fill to full, overflow on 17th, drain in order
        uart_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < D; i++) write1(8'(i), 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        chk("fill_ovf_clear", int'(overflow), 0);
        write1(8'hFF, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        uart_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            uart_take(i % 3, got_d, got_e, got_ok);
            if (got_ok) chk($sformatf("drain_byte%0d", i), int'(got_d), i);
        end
        repeat (10) tick();
        chk("no_ff_emitted", int'(Tx_valid), 0);
        chk("drain_empty", int'(empty), 1);

        // Full FIFO, pop in IDLE with simultaneous write
        uart_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < D; i++) write1(8'(8'h10 + i), 1'b0);
        chk("t5_full", int'(full), 1);
        uart_ready = 1'b1;
        tick(); tick();
        write1(8'h77, 1'b0);
        chk("t5_count", int'(count), 16);
        chk("t5_ovf", int'(overflow), 0);
        chk("t5_valid", int'(Tx_valid), 1);
        for (int i = 0; i <= D; i++) begin
            uart_take(1, got_d, got_e, got_ok);
            if (got_ok) chk($sformatf("t5_byte%0d", i), int'(got_d), (i == D) ? 'h77 : 'h10 + i);
        end

        // Random push/drain with wrap-around
        fork
            begin
                int n;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    n = 0;
                    while (full && n < 300) begin
                        tick();
                        n++;
                    end
                    exp_q.push_back(8'($urandom_range(0, 255)));
                    write1(exp_q[$], 1'b0);
                end
            end
            begin
                logic [W-1:0] rd;
                logic         re;
                bit           rok;
                for (int i = 0; i < 40; i++) begin
                    uart_take(int'($urandom_range(0, 4)), rd, re, rok);
                    if (rok) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL rand_extra_byte actual=0x%0h expected=none", rd);
                        end else begin
                            chk($sformatf("rand_byte%0d", i), int'(rd), int'(exp_q.pop_front()));
                        end
                    end
                end
            end
        join
        repeat (5) tick();
        chk("rand_count_zero", int'(count), 0);
        chk("rand_empty", int'(empty), 1);
        chk("rand_no_ovf", int'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
